regfile_dual: RTL and testbench

Parametrised successor to the CPU register file. It holds NUM_REGS byte-wide (WIDTH) registers that can be addressed singly or as aligned high/low pairs. It adds a second read port, concurrent pair arithmetic and write in the same cycle, pair exchange, optional write-to-read bypass, and registered zero/carry status for loop-counter pairs. It sits between the decoder/sequencer and the ALU/address bus.

---
 rtl/regfile_dual.sv | 163 ++++++++++++++++
 tb/tb_regfile_dual.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dual.sv
// Dual-read register file with byte/pair addressing, concurrent pair arithmetic
// or pair exchange alongside the write port, and registered loop-counter status.
module regfile_dual #(
  parameter int unsigned  WIDTH    = 8,
  parameter int unsigned  NUM_REGS = 12,
  parameter bit           BYPASS   = 1'b0,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_pair,
  input  logic [AW-1:0]     wr_sel,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic [AW-1:0]     rd_a_sel,
  input  logic [AW-1:0]     rd_b_sel,
  input  logic              rd_a_pair,
  input  logic              rd_b_pair,
  output logic [2*WIDTH-1:0] rd_a_data,
  output logic [2*WIDTH-1:0] rd_b_data,
  input  logic [2:0]        ext_op,
  input  logic [AW-1:0]     ext_sel,
  input  logic [AW-1:0]     ext_sel2,
  input  logic [WIDTH-1:0]  ext_imm,
  output logic              ext_zero,
  output logic              ext_carry,
  output logic              wr_drop
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned NP = NUM_REGS / 2;

  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_INC2 = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_XCHG = 3'b101;

  logic [WIDTH-1:0]    regs_q  [NUM_REGS];
  logic [WIDTH-1:0]    regs_d  [NUM_REGS];
  logic [WIDTH-1:0]    wr_val  [NUM_REGS];
  logic [WIDTH-1:0]    rd_view [NUM_REGS];
  logic [NUM_REGS-1:0] wr_mask, ext_mask, wr_eff;
  logic [NP-1:0]       pa_hit, pb_hit;
  logic [PW-1:0]       pa_val, pb_val, imm_ext, imm_mag;
  logic [SW-1:0]       sum;
  logic                arith, xchg, conflict;

  assign imm_ext = {{WIDTH{ext_imm[WIDTH-1]}}, ext_imm};
  assign imm_mag = PW'(0) - imm_ext;

  // Write-port byte mask and per-byte data; out-of-range selects match nothing.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      wr_val[i] = wr_data[WIDTH-1:0];
      if (wr_pair) begin
        if (AW'(i >> 1) == (wr_sel >> 1)) begin
          wr_mask[i] = wr_en;
          if (i % 2 == 0) wr_val[i] = wr_data[PW-1:WIDTH];
        end
      end else if (AW'(i) == wr_sel) begin
        wr_mask[i] = wr_en;
      end
    end
  end

  // Locate the ext-op pairs and their current values.
  always_comb begin
    pa_hit = '0;
    pb_hit = '0;
    pa_val = '0;
    pb_val = '0;
    for (int k = 0; k < int'(NP); k++) begin
      if (AW'(k) == (ext_sel >> 1)) begin
        pa_hit[k] = 1'b1;
        pa_val    = {regs_q[2*k], regs_q[2*k+1]};
      end
      if (AW'(k) == (ext_sel2 >> 1)) begin
        pb_hit[k] = 1'b1;
        pb_val    = {regs_q[2*k], regs_q[2*k+1]};
      end
    end
  end

  // Pair arithmetic in 2W+1 bits; the top bit is carry (add) or borrow (subtract).
  always_comb begin
    arith = 1'b0;
    xchg  = 1'b0;
    sum   = {1'b0, pa_val};
    case (ext_op)
      OP_INC:  begin arith = |pa_hit; sum = {1'b0, pa_val} + SW'(1); end
      OP_DEC:  begin arith = |pa_hit; sum = {1'b0, pa_val} - SW'(1); end
      OP_INC2: begin arith = |pa_hit; sum = {1'b0, pa_val} + SW'(2); end
      OP_ADD: begin
        arith = |pa_hit;
        if (ext_imm[WIDTH-1]) sum = {1'b0, pa_val} - {1'b0, imm_mag};
        else                  sum = {1'b0, pa_val} + {1'b0, imm_ext};
      end
      OP_XCHG: xchg = (|pa_hit) && (|pb_hit);
      default: ;
    endcase
  end

  // Any byte shared by the ext op and the write port discards the whole write.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      ext_mask[i] = (arith && pa_hit[i/2]) || (xchg && (pa_hit[i/2] || pb_hit[i/2]));
    end
    conflict = |(wr_mask & ext_mask);
    wr_eff   = conflict ? '0 : wr_mask;
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i]  = wr_eff[i] ? wr_val[i] : regs_q[i];
      rd_view[i] = (BYPASS && wr_eff[i]) ? wr_val[i] : regs_q[i];
    end
    for (int k = 0; k < int'(NP); k++) begin
      if (arith && pa_hit[k]) {regs_d[2*k], regs_d[2*k+1]} = sum[PW-1:0];
      if (xchg && pa_hit[k])  {regs_d[2*k], regs_d[2*k+1]} = pb_val;
      if (xchg && pb_hit[k])  {regs_d[2*k], regs_d[2*k+1]} = pa_val;
    end
  end

  function automatic logic [PW-1:0] read_port(input logic [AW-1:0] sel, input logic pair,
                                              input logic [WIDTH-1:0] view [NUM_REGS]);
    logic [PW-1:0] data;
    data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (pair) begin
        if (AW'(i >> 1) == (sel >> 1)) begin
          if (i % 2 == 0) data[PW-1:WIDTH] = view[i];
          else            data[WIDTH-1:0]  = view[i];
        end
      end else if (AW'(i) == sel) begin
        data = {WIDTH'(0), view[i]};
      end
    end
    return data;
  endfunction

  assign rd_a_data = read_port(rd_a_sel, rd_a_pair, rd_view);
  assign rd_b_data = read_port(rd_b_sel, rd_b_pair, rd_view);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      ext_zero  <= 1'b0;
      ext_carry <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      wr_drop <= conflict;
      if (arith) begin
        ext_zero  <= (sum[PW-1:0] == '0);
        ext_carry <= sum[PW];
      end
    end
  end

endmodule

// File: tb/tb_regfile_dual.sv
// Directed bench for regfile_dual: one instance without and one with bypass.
module tb_regfile_dual;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, DEC = 3'd2, INC2 = 3'd3, ADD = 3'd4, XCHG = 3'd5;
  localparam logic T = 1'b1, F = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_pair, rd_a_pair, rd_b_pair;
  logic [3:0]  wr_sel, rd_a_sel, rd_b_sel, ext_sel, ext_sel2;
  logic [15:0] wr_data;
  logic [2:0]  ext_op;
  logic [7:0]  ext_imm;
  logic [15:0] a0, b0, a1, b1;
  logic        z0, c0, d0, z1, c1, d1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_dual #(.WIDTH(8), .NUM_REGS(12), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_pair(wr_pair), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_a_pair(rd_a_pair), .rd_b_pair(rd_b_pair),
    .rd_a_data(a0), .rd_b_data(b0), .ext_op(ext_op), .ext_sel(ext_sel), .ext_sel2(ext_sel2),
    .ext_imm(ext_imm), .ext_zero(z0), .ext_carry(c0), .wr_drop(d0));

  regfile_dual #(.WIDTH(8), .NUM_REGS(12), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_pair(wr_pair), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_a_pair(rd_a_pair), .rd_b_pair(rd_b_pair),
    .rd_a_data(a1), .rd_b_data(b1), .ext_op(ext_op), .ext_sel(ext_sel), .ext_sel2(ext_sel2),
    .ext_imm(ext_imm), .ext_zero(z1), .ext_carry(c1), .wr_drop(d1));

  typedef struct {
    logic        we, wp;
    logic [3:0]  ws;
    logic [15:0] wd;
    logic [2:0]  op;
    logic [3:0]  s, s2;
    logic [7:0]  imm;
    logic [3:0]  ra;
    logic        rap;
    logic [3:0]  rb;
    logic        rbp;
    logic [15:0] ea, eb;
    logic        ez, ec, ed;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic we, input logic wp, input logic [3:0] ws,
                              input logic [15:0] wd, input logic [2:0] op, input logic [3:0] s,
                              input logic [3:0] s2, input logic [7:0] imm, input logic [3:0] ra,
                              input logic rap, input logic [3:0] rb, input logic rbp,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic ez, input logic ec, input logic ed);
    vec_t v;
    v.we = we; v.wp = wp; v.ws = ws; v.wd = wd; v.op = op; v.s = s; v.s2 = s2; v.imm = imm;
    v.ra = ra; v.rap = rap; v.rb = rb; v.rbp = rbp; v.ea = ea; v.eb = eb;
    v.ez = ez; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_pair = 1'b0; wr_sel = 4'd0; wr_data = 16'h0000;
    ext_op = NOP; ext_sel = 4'd0; ext_sel2 = 4'd0; ext_imm = 8'h00;
  endtask

  task automatic apply(input int n, input vec_t v);
    @(negedge clk);
    wr_en = v.we; wr_pair = v.wp; wr_sel = v.ws; wr_data = v.wd;
    ext_op = v.op; ext_sel = v.s; ext_sel2 = v.s2; ext_imm = v.imm;
    rd_a_sel = v.ra; rd_a_pair = v.rap; rd_b_sel = v.rb; rd_b_pair = v.rbp;
    @(posedge clk);
    #1 idle();
    #1;
    chk16($sformatf("v%0d_rd_a", n), a0, v.ea);
    chk16($sformatf("v%0d_rd_b", n), b0, v.eb);
    chk16($sformatf("v%0d_rd_a_byp", n), a1, v.ea);
    chk16($sformatf("v%0d_rd_b_byp", n), b1, v.eb);
    chk1($sformatf("v%0d_zero", n), z0, v.ez);
    chk1($sformatf("v%0d_carry", n), c0, v.ec);
    chk1($sformatf("v%0d_drop", n), d0, v.ed);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    rd_a_sel = 4'd0; rd_a_pair = 1'b1; rd_b_sel = 4'd1; rd_b_pair = 1'b0;

    //       we wp ws     wd        op    s     s2    imm    ra   rap rb   rbp exp_a     exp_b    z c d
    tbl[0]  = mk(F,F,4'd0, 16'h0000,NOP, 4'd0, 4'd0, 8'h00, 4'd0, T,4'd11,F,16'h0000,16'h0000,F,F,F);
    tbl[1]  = mk(T,T,4'd4, 16'hFFFF,NOP, 4'd0, 4'd0, 8'h00, 4'd4, T,4'd5, F,16'hFFFF,16'h00FF,F,F,F);
    tbl[2]  = mk(F,F,4'd0, 16'h0000,INC, 4'd5, 4'd0, 8'h00, 4'd4, T,4'd4, F,16'h0000,16'h0000,T,T,F);
    tbl[3]  = mk(F,F,4'd0, 16'h0000,DEC, 4'd4, 4'd0, 8'h00, 4'd4, T,4'd4, F,16'hFFFF,16'h00FF,F,T,F);
    tbl[4]  = mk(T,T,4'd8, 16'h0010,NOP, 4'd0, 4'd0, 8'h00, 4'd8, T,4'd9, F,16'h0010,16'h0010,F,T,F);
    tbl[5]  = mk(F,F,4'd0, 16'h0000,ADD, 4'd8, 4'd0, 8'hF0, 4'd8, T,4'd4, T,16'h0000,16'hFFFF,T,F,F);
    tbl[6]  = mk(T,T,4'd8, 16'h0010,NOP, 4'd0, 4'd0, 8'h00, 4'd8, T,4'd8, T,16'h0010,16'h0010,T,F,F);
    tbl[7]  = mk(F,F,4'd0, 16'h0000,ADD, 4'd9, 4'd0, 8'h7F, 4'd8, T,4'd9, F,16'h008F,16'h008F,F,F,F);
    tbl[8]  = mk(T,T,4'd0, 16'h00FF,NOP, 4'd0, 4'd0, 8'h00, 4'd0, T,4'd1, F,16'h00FF,16'h00FF,F,F,F);
    tbl[9]  = mk(T,F,4'd5, 16'h123C,INC, 4'd0, 4'd0, 8'h00, 4'd0, T,4'd5, F,16'h0100,16'h003C,F,F,F);
    tbl[10] = mk(T,F,4'd1, 16'h0077,INC, 4'd1, 4'd0, 8'h00, 4'd0, T,4'd1, F,16'h0101,16'h0001,F,F,T);
    tbl[11] = mk(F,F,4'd0, 16'h0000,NOP, 4'd0, 4'd0, 8'h00, 4'd0, T,4'd4, T,16'h0101,16'hFF3C,F,F,F);
    tbl[12] = mk(T,T,4'd4, 16'h1234,DEC, 4'd10,4'd0, 8'h00, 4'd4, T,4'd10,T,16'h1234,16'hFFFF,F,T,F);
    tbl[13] = mk(T,T,4'd9, 16'hABCD,NOP, 4'd0, 4'd0, 8'h00, 4'd8, T,4'd4, T,16'hABCD,16'h1234,F,T,F);
    tbl[14] = mk(F,F,4'd0, 16'h0000,XCHG,4'd4, 4'd8, 8'h00, 4'd4, T,4'd8, T,16'hABCD,16'h1234,F,T,F);
    tbl[15] = mk(F,F,4'd0, 16'h0000,XCHG,4'd4, 4'd5, 8'h00, 4'd4, T,4'd4, F,16'hABCD,16'h00AB,F,T,F);
    tbl[16] = mk(T,T,4'd12,16'h5555,INC, 4'd14,4'd0, 8'h00, 4'd12,F,4'd14,T,16'h0000,16'h0000,F,T,F);
    tbl[17] = mk(T,F,4'd9, 16'h0099,XCHG,4'd4, 4'd8, 8'h00, 4'd8, T,4'd4, T,16'hABCD,16'h1234,F,T,T);
    tbl[18] = mk(F,F,4'd0, 16'h0000,INC2,4'd10,4'd0, 8'h00, 4'd10,T,4'd11,F,16'h0001,16'h0001,F,T,F);
    tbl[19] = mk(F,F,4'd0, 16'h0000,ADD, 4'd10,4'd0, 8'hFF, 4'd10,T,4'd8, T,16'h0000,16'hABCD,T,F,F);
    tbl[20] = mk(F,F,4'd0, 16'h0000,ADD, 4'd11,4'd0, 8'h80, 4'd10,T,4'd10,F,16'hFF80,16'h00FF,F,T,F);
    tbl[21] = mk(F,F,4'd0, 16'h0000,ADD, 4'd10,4'd0, 8'h7F, 4'd10,T,4'd11,F,16'hFFFF,16'h00FF,F,F,F);
    tbl[22] = mk(F,F,4'd0, 16'h0000,ADD, 4'd10,4'd0, 8'h01, 4'd10,T,4'd0, T,16'h0000,16'h0101,T,T,F);
    tbl[23] = mk(T,F,4'd11,16'h0042,XCHG,4'd10,4'd14,8'h00, 4'd10,T,4'd11,F,16'h0042,16'h0042,T,T,F);

    // Power-on reset state while rst is held low.
    #2;
    chk16("por_rd_a", a0, 16'h0000);
    chk1("por_zero", z0, 1'b0);
    chk1("por_carry", c0, 1'b0);
    chk1("por_drop", d0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) apply(i, tbl[i]);

    // Bypass: same-cycle write data visible only on the bypass instance.
    @(negedge clk);
    wr_en = 1'b1; wr_pair = 1'b1; wr_sel = 4'd6; wr_data = 16'hBEEF;
    rd_a_sel = 4'd6; rd_a_pair = 1'b1; rd_b_sel = 4'd7; rd_b_pair = 1'b0;
    #1;
    chk16("byp_pair_a", a1, 16'hBEEF);
    chk16("byp_single_b", b1, 16'h00EF);
    chk16("nobyp_pair_a", a0, 16'h0000);
    chk16("nobyp_single_b", b0, 16'h0000);
    @(posedge clk);
    #1 idle();
    #1;
    chk16("nobyp_after_a", a0, 16'hBEEF);
    chk16("nobyp_after_b", b0, 16'h00EF);

    // Dropped writes and ext-op results are never bypassed.
    @(negedge clk);
    ext_op = INC; ext_sel = 4'd6;
    wr_en = 1'b1; wr_pair = 1'b0; wr_sel = 4'd7; wr_data = 16'h0011;
    #1;
    chk16("byp_drop_a", a1, 16'hBEEF);
    chk16("byp_drop_b", b1, 16'h00EF);
    @(posedge clk);
    #1 idle();
    #1;
    chk16("byp_inc_a", a1, 16'hBEF0);
    chk16("byp_inc_b", b1, 16'h00F0);
    chk1("byp_inc_drop", d1, 1'b1);

    // Reset: fill with 0xA5, create a drop pulse, then assert rst mid-cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_pair = 1'b0; wr_sel = 4'(i); wr_data = 16'h00A5;
    end
    @(negedge clk);
    idle();
    rd_a_sel = 4'd3; rd_a_pair = 1'b0; rd_b_sel = 4'd10; rd_b_pair = 1'b1;
    #1;
    chk16("fill_rd_a", a0, 16'h00A5);
    chk16("fill_rd_b", b0, 16'hA5A5);
    @(negedge clk);
    ext_op = INC; ext_sel = 4'd0; wr_en = 1'b1; wr_sel = 4'd0; wr_data = 16'h0011;
    @(posedge clk);
    #1 idle();
    rd_b_sel = 4'd0;
    #1;
    chk16("pre_rst_pair0", b0, 16'hA5A6);
    chk1("pre_rst_drop", d0, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk16("rst_rd_a", a0, 16'h0000);
    chk16("rst_rd_b", b1, 16'h0000);
    chk1("rst_drop", d0, 1'b0);
    chk1("rst_zero", z0, 1'b0);
    chk1("rst_carry", c0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_a_sel = 4'(2 * i); rd_a_pair = 1'b1; rd_b_sel = 4'(2 * i + 1); rd_b_pair = 1'b0;
      #1;
      chk16($sformatf("rst_pair%0d", 2 * i), a0, 16'h0000);
      chk16($sformatf("rst_reg%0d", 2 * i + 1), b1, 16'h0000);
    end

    // The first edge after release performs a normal write.
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b1; wr_pair = 1'b1; wr_sel = 4'd0; wr_data = 16'h5A5A;
    rd_a_sel = 4'd0; rd_a_pair = 1'b1;
    @(posedge clk);
    #1 idle();
    #1;
    chk16("post_rst_write", a0, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
